// File: rtl/reg_dump.sv
// Register-file dump engine: walks a (possibly wrapping) index range, reads
// each register and streams it out with valid/ready, then pulses done.
module reg_dump #(
  parameter int INCLUDE_R0 = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  first_reg,
  input  logic [4:0]  last_reg,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  cur_idx, cur_nx;
  logic [4:0]  end_idx, end_nx;
  logic [4:0]  nxt_idx;
  logic [31:0] data_q;
  logic [4:0]  idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_idx <= 5'd0;
      end_idx <= 5'd0;
      data_q  <= 32'd0;
      idx_q   <= 5'd0;
    end else begin
      state   <= state_nx;
      cur_idx <= cur_nx;
      end_idx <= end_nx;
      if (state == READ) begin
        data_q <= rd_data;
        idx_q  <= cur_idx;
      end
    end
  end

  // Index 0 is skipped without a READ visit when INCLUDE_R0 is clear.
  always_comb begin
    state_nx = state;
    cur_nx   = cur_idx;
    end_nx   = end_idx;
    nxt_idx  = idx_q + 5'd1;
    case (state)
      IDLE: begin
        if (start) begin
          end_nx = last_reg;
          if (INCLUDE_R0 == 0 && first_reg == 5'd0) begin
            if (last_reg == 5'd0) begin
              state_nx = DONE;
            end else begin
              cur_nx   = 5'd1;
              state_nx = READ;
            end
          end else begin
            cur_nx   = first_reg;
            state_nx = READ;
          end
        end
      end
      READ: state_nx = SEND;
      SEND: begin
        if (out_ready) begin
          if (idx_q == end_idx) begin
            state_nx = DONE;
          end else if (INCLUDE_R0 == 0 && nxt_idx == 5'd0) begin
            if (end_idx == 5'd0) begin
              state_nx = DONE;
            end else begin
              cur_nx   = 5'd1;
              state_nx = READ;
            end
          end else begin
            cur_nx   = nxt_idx;
            state_nx = READ;
          end
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign rd_addr   = (state == READ) ? cur_idx : 5'd0;
  assign out_valid = (state == SEND);
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = (state == SEND) && (idx_q == end_idx);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule
